// File: rtl/comma_aligner.sv
// comma_aligner: hunts for the K28.5 comma in the serial stream and emits aligned 10-bit code groups
// Ports: BitCLK bit clock; Reset async active-low; Serial data in (MSB first); Realign forces HUNT;
//        RxParallel_10 aligned group (bit 9 first received); RxValid one-cycle group strobe;
//        CommaDet comma seen in the window on the previous edge; Locked high in LOCKED.
module comma_aligner #(
   parameter int LOCK_CNT   = 3,
   parameter int UNLOCK_CNT = 2
) (
   input  logic       BitCLK,
   input  logic       Reset,
   input  logic       Serial,
   input  logic       Realign,
   output logic [9:0] RxParallel_10,
   output logic       RxValid,
   output logic       CommaDet,
   output logic       Locked
);
   localparam int GW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
   localparam int MW = (UNLOCK_CNT < 2) ? 1 : $clog2(UNLOCK_CNT + 1);
   localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_CNT);
   localparam logic [MW-1:0] MISS_MAX = MW'(UNLOCK_CNT);
   localparam logic [1:0] HUNT   = 2'd0;
   localparam logic [1:0] SYNC   = 2'd1;
   localparam logic [1:0] LOCKED = 2'd2;

   logic [9:0]    sr;
   logic [3:0]    bit_cnt;
   logic [GW-1:0] good_cnt, good_nx, good_inc;
   logic [MW-1:0] miss_cnt, miss_nx, miss_inc;
   logic [1:0]    state, next_state;
   logic          comma, aligned, boundary;

   assign comma    = (sr == 10'b0011111010) || (sr == 10'b1100000101);
   assign aligned  = bit_cnt == 4'd9;
   assign good_inc = &good_cnt ? good_cnt : good_cnt + GW'(1);
   assign miss_inc = &miss_cnt ? miss_cnt : miss_cnt + MW'(1);

   // Realign wins over everything, including a comma in the same cycle
   always_comb begin
      next_state = state;
      boundary   = 1'b0;
      good_nx    = good_cnt;
      miss_nx    = miss_cnt;
      if (Realign) begin
         next_state = HUNT;
         good_nx    = '0;
         miss_nx    = '0;
      end else begin
         case (state)
            HUNT: if (comma) begin
               boundary   = 1'b1;
               good_nx    = GW'(1);
               next_state = (LOCK_CNT == 1) ? LOCKED : SYNC;
            end
            SYNC: begin
               boundary = aligned || comma;
               if (comma && !aligned) good_nx = GW'(1);
               else if (comma) begin
                  good_nx = good_inc;
                  if (good_inc >= GOOD_MAX) begin
                     next_state = LOCKED;
                     miss_nx    = '0;
                  end
               end
            end
            LOCKED: begin
               boundary = aligned;
               if (comma && aligned) miss_nx = '0;
               else if (comma && miss_inc >= MISS_MAX) begin
                  boundary   = 1'b1;
                  good_nx    = GW'(1);
                  miss_nx    = '0;
                  next_state = SYNC;
               end else if (comma) miss_nx = miss_inc;
            end
            default: next_state = HUNT;
         endcase
      end
   end

   always_ff @(posedge BitCLK or negedge Reset) begin
      if (!Reset) begin
         sr            <= '0;
         bit_cnt       <= '0;
         good_cnt      <= '0;
         miss_cnt      <= '0;
         state         <= HUNT;
         RxParallel_10 <= '0;
         RxValid       <= 1'b0;
         CommaDet      <= 1'b0;
         Locked        <= 1'b0;
      end else begin
         sr            <= {sr[8:0], Serial};
         bit_cnt       <= (boundary || aligned) ? 4'd0 : bit_cnt + 4'd1;
         good_cnt      <= good_nx;
         miss_cnt      <= miss_nx;
         state         <= next_state;
         RxParallel_10 <= boundary ? sr : RxParallel_10;
         RxValid       <= boundary;
         CommaDet      <= comma;
         Locked        <= next_state == LOCKED;
      end
   end
endmodule

// File: tb/tb_comma_aligner.sv
// tb_comma_aligner: scoreboard bench for comma_aligner against a bit-history reference model
module tb_comma_aligner;
   localparam logic [9:0] KM = 10'h0FA;
   localparam logic [9:0] KP = 10'h305;
   localparam logic [9:0] DW = 10'h2AA;
   localparam int LOCK_N = 3;
   localparam int UNLOCK_N = 2;

   logic       BitCLK = 1'b0;
   logic       Reset, Serial, Realign;
   logic [9:0] RxParallel_10;
   logic       RxValid, CommaDet, Locked;

   comma_aligner #(.LOCK_CNT(LOCK_N), .UNLOCK_CNT(UNLOCK_N)) dut (
      .BitCLK(BitCLK), .Reset(Reset), .Serial(Serial), .Realign(Realign),
      .RxParallel_10(RxParallel_10), .RxValid(RxValid), .CommaDet(CommaDet), .Locked(Locked)
   );

   initial forever #5 BitCLK = ~BitCLK;

   typedef struct { bit v; bit lk; bit cd; } ctl_t;
   ctl_t       ctl_q[$];
   logic [9:0] data_q[$];
   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: last ten received bits, mode, counts, and the edge number of the last boundary
   int         mode, good_m, miss_m, edge_m, last_b;
   logic [9:0] hist;

   task automatic model_reset();
      mode = 0; good_m = 0; miss_m = 0; edge_m = 0; last_b = 0; hist = '0;
   endtask

   task automatic model_step(input logic s, input logic ra);
      bit c, al, v;
      ctl_t e;
      c  = (hist == KM) || (hist == KP);
      al = (edge_m > last_b) && ((edge_m - last_b) % 10 == 0);
      v  = 0;
      if (ra) begin
         mode = 0; good_m = 0; miss_m = 0;
      end else if (mode == 0) begin
         if (c) begin v = 1; good_m = 1; mode = (LOCK_N == 1) ? 2 : 1; end
      end else if (mode == 1) begin
         if (c && !al) begin v = 1; good_m = 1; end
         else begin
            v = al;
            if (c) begin
               good_m++;
               if (good_m >= LOCK_N) begin mode = 2; miss_m = 0; end
            end
         end
      end else begin
         v = al;
         if (c && al) miss_m = 0;
         else if (c && miss_m + 1 >= UNLOCK_N) begin v = 1; good_m = 1; miss_m = 0; mode = 1; end
         else if (c) miss_m++;
      end
      if (v) begin
         last_b = edge_m;
         data_q.push_back(hist);
      end
      e.v = v; e.lk = (mode == 2); e.cd = c;
      ctl_q.push_back(e);
      hist = {hist[8:0], s};
      edge_m++;
   endtask

   task automatic tick(input logic s, input logic ra);
      Serial = s;
      Realign = ra;
      @(posedge BitCLK);
      model_step(s, ra);
      #1 Realign = 1'b0;
   endtask

   task automatic send_word(input logic [9:0] w, input logic ra0);
      for (int i = 9; i >= 0; i--) tick(w[i], (i == 9) ? ra0 : 1'b0);
   endtask

   // Monitor: every DUT cycle is compared against the expectation queued for that edge
   initial begin
      ctl_t c;
      logic [9:0] w;
      forever begin
         @(negedge BitCLK);
         if (Reset === 1'b1 && ctl_q.size() > 0) begin
            c = ctl_q.pop_front();
            chk("rx_valid", {31'd0, RxValid}, {31'd0, c.v});
            chk("locked", {31'd0, Locked}, {31'd0, c.lk});
            chk("comma_det", {31'd0, CommaDet}, {31'd0, c.cd});
            if (c.v && data_q.size() > 0) begin
               w = data_q.pop_front();
               chk("rx_word", {22'd0, RxParallel_10}, {22'd0, w});
            end
         end
      end
   end

   initial begin
      int r;
      Reset = 1'b0; Serial = 1'b0; Realign = 1'b0;
      model_reset();
      repeat (2) @(posedge BitCLK);
      #1;
      chk("reset_word", {22'd0, RxParallel_10}, 32'd0);
      chk("reset_flags", {29'd0, RxValid, CommaDet, Locked}, 32'd0);
      @(negedge BitCLK);
      Reset = 1'b1;
      // initial lock after a random bit offset
      for (int i = 0; i < 7; i++) tick(1'($urandom_range(0, 1)), 1'b0);
      send_word(KM, 1'b0); send_word(DW, 1'b0);
      send_word(KM, 1'b0); send_word(DW, 1'b0);
      chk("lock_two_commas", {31'd0, Locked}, 32'd0);
      send_word(KM, 1'b0); send_word(DW, 1'b0);
      chk("lock_three_commas", {31'd0, Locked}, 32'd1);
      // opposite disparity comma while locked
      send_word(KP, 1'b0); send_word(DW, 1'b0);
      chk("rdp_locked", {31'd0, Locked}, 32'd1);
      // one-bit slip
      tick(1'b0, 1'b0);
      send_word(KM, 1'b0); send_word(DW, 1'b0);
      chk("slip_first_miss", {31'd0, Locked}, 32'd1);
      send_word(KP, 1'b0); send_word(DW, 1'b0);
      chk("slip_second_miss", {31'd0, Locked}, 32'd0);
      send_word(KM, 1'b0); send_word(DW, 1'b0);
      chk("relock_one", {31'd0, Locked}, 32'd0);
      send_word(KM, 1'b0); send_word(DW, 1'b0);
      chk("relock_two", {31'd0, Locked}, 32'd1);
      // Realign while a comma is being detected
      send_word(KM, 1'b0); send_word(DW, 1'b1);
      chk("realign_unlock", {31'd0, Locked}, 32'd0);
      send_word(DW, 1'b0); send_word(DW, 1'b0);
      // SYNC with good_cnt=1, then a comma three bits late
      send_word(KM, 1'b0); send_word(DW, 1'b0);
      tick(1'b0, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0);
      send_word(KM, 1'b0); send_word(DW, 1'b0);
      send_word(KM, 1'b0); send_word(DW, 1'b0);
      chk("sync_realign_nolock", {31'd0, Locked}, 32'd0);
      send_word(KM, 1'b0); send_word(DW, 1'b0);
      chk("sync_realign_lock", {31'd0, Locked}, 32'd1);
      // randomized traffic
      for (int n = 0; n < 250; n++) begin
         r = $urandom_range(0, 5);
         if (r < 2) send_word($urandom_range(0, 1) ? KM : KP, 1'b0);
         else if (r < 5) send_word(10'($urandom_range(0, 1023)), 1'($urandom_range(0, 60) == 0));
         else for (int i = 0; i < $urandom_range(1, 3); i++) tick(1'($urandom_range(0, 1)), 1'b0);
      end
      send_word(KM, 1'b0); send_word(DW, 1'b0);
      send_word(KM, 1'b0); send_word(DW, 1'b0);
      send_word(KM, 1'b0); send_word(DW, 1'b0);
      // async reset in the middle of a word
      for (int i = 0; i < 4; i++) tick(1'($urandom_range(0, 1)), 1'b0);
      #1 Reset = 1'b0;
      ctl_q.delete();
      data_q.delete();
      #1;
      chk("async_word", {22'd0, RxParallel_10}, 32'd0);
      chk("async_flags", {29'd0, RxValid, CommaDet, Locked}, 32'd0);
      @(negedge BitCLK);
      @(negedge BitCLK);
      model_reset();
      Reset = 1'b1;
      send_word(KP, 1'b0); send_word(DW, 1'b0);
      send_word(KM, 1'b0); send_word(DW, 1'b0);
      send_word(KP, 1'b0); send_word(DW, 1'b0);
      chk("relock_after_reset", {31'd0, Locked}, 32'd1);
      repeat (3) @(negedge BitCLK);
      chk("scoreboard_drained", ctl_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/comma_aligner.md
Name: comma_aligner

Overview:
- Receive-side word aligner.
- Takes the recovered serial bit stream and finds the 10-bit word boundary by hunting for the K28.5 comma.
- Emits aligned 10-bit code groups with a one-cycle strobe.
- Sits between the sampler/CDR output and the decoder. It is the receive counterpart of the PISO and replaces the free-running SIPO framing.

Parameters:
- LOCK_CNT, 3, number of consecutive aligned commas (including the first) required to enter LOCKED.
- UNLOCK_CNT, 2, number of consecutive misaligned commas in LOCKED that force realignment.

Ports:
- BitCLK  input  1  recovered bit clock; the single clock, all logic on its rising edge.
- Reset  input  1  asynchronous, active-low reset (Reset=0 resets).
- Serial  input  1  recovered serial data, one bit per BitCLK. The first transmitted bit of a code group is the MSB.
- Realign  input  1  synchronous request; when sampled 1, forces HUNT.
- RxParallel_10  output  10  aligned code group; bit 9 is the first received bit.
- RxValid  output  1  one-cycle strobe; RxParallel_10 is new in this cycle.
- CommaDet  output  1  one-cycle pulse; the 10-bit window matched a comma on the previous edge.
- Locked  output  1  high in LOCKED state.

Behaviour:
- **Reset values.** Reset=0 asynchronously clears:
  - shift register sr[9:0], bit_cnt, good_cnt and miss_cnt to 0
  - RxParallel_10=0, RxValid=0, CommaDet=0, Locked=0
  - state=HUNT
- **Shifting.** Every edge: sr <= {sr[8:0], Serial}.
- **Comma match.** Combinational on the registered sr: comma = (sr==10'b0011111010) || (sr==10'b1100000101), i.e. K28.5 in RD- or RD+.
- **Alignment.** aligned = (bit_cnt==9).
- **Boundary event.** When a boundary occurs (defined per state):
  - RxParallel_10 <= sr, RxValid <= 1, bit_cnt <= 0.
  - Otherwise RxValid <= 0, bit_cnt <= (bit_cnt==9) ? 0 : bit_cnt+1.
- **CommaDet** <= comma, in every state.
- **Latency.** The last bit of a code group is captured into sr on edge k. RxParallel_10 and RxValid are valid after edge k+1. Once aligned, RxValid recurs every 10 cycles exactly.
- **HUNT.**
  - No boundary events from bit_cnt; RxValid stays 0 except on a comma.
  - On comma: boundary event (the comma word is output), good_cnt <= 1, go to SYNC.
  - If LOCK_CNT==1, go directly to LOCKED.
- **SYNC.**
  - Boundary event whenever aligned.
  - comma && aligned: good_cnt+1. Reaching LOCK_CNT goes to LOCKED; then miss_cnt <= 0.
  - comma && !aligned: immediate realign. Boundary event at the current position, good_cnt <= 1, stay in SYNC.
- **LOCKED.**
  - Boundary event whenever aligned.
  - comma && aligned: miss_cnt <= 0.
  - comma && !aligned: miss_cnt+1 and no realign.
    - When miss_cnt+1 reaches UNLOCK_CNT: realign at this comma (boundary event), good_cnt <= 1, miss_cnt <= 0, go to SYNC.
  - Non-comma data never changes miss_cnt.
- **Locked output** is registered: Locked <= (next_state==LOCKED).
- **Realign=1** takes priority over all transitions:
  - next state HUNT; good_cnt and miss_cnt cleared; Locked <= 0.
  - A comma in that same cycle is ignored for alignment.
  - CommaDet still pulses.
- **Counter saturation.** good_cnt and miss_cnt saturate and never wrap. bit_cnt wraps 9->0.
- **Overlapping comma windows.** The comma pattern cannot self-overlap within 10 bits, so no special handling is needed.
- **Mid-operation reset.** Reset asserted at any time returns everything to reset values immediately. A partially shifted word is discarded.

Test Plan:
- **Initial lock.** After reset, send 7 random bits, then K28.5 RD- (0011111010), then D-words interleaved with 2 more K28.5 at 10-bit spacing. Required:
  - first RxValid 1 cycle after the comma's last bit, RxParallel_10=0x0FA
  - RxValid every 10 cycles thereafter
  - Locked rises 1 cycle after the 3rd comma's detection edge
- **Both disparities.** Send K28.5 RD+ (1100000101). Required: RxParallel_10=0x305 and CommaDet pulse.
- **Slip while locked.** Once locked, insert one extra bit, then send commas. Required:
  - first misaligned comma: no realign, Locked stays 1
  - second misaligned comma: RxValid at the new boundary, Locked drops to 0
  - relock after 2 further aligned commas
- **SYNC realign and false-lock.** In SYNC with good_cnt=1, a comma appears shifted by 3 bits. Required: immediate realign, good_cnt restarts at 1, Locked stays 0.
- **Realign and reset mid-stream.** Drive Realign=1 for one cycle while locked with a comma present. Required:
  - Locked=0 and RxValid stops
  - the next comma restarts alignment
- **Async reset mid-word.** Assert Reset=0 mid-word. Required: all outputs 0 immediately, with no BitCLK edge needed.
